clint_vec: RTL and testbench

- Parametrised successor to the core-local interrupt controller.
- Takes NUM_IRQ external interrupt lines, each with its own enable, and latches them into a pending register (per-source level or edge trigger).
- Arbitrates the pending sources against synchronous exceptions (ECALL/EBREAK) and MRET, then runs the mepc/mstatus/mcause CSR write sequence.
- Issues the redirect to ex, with optional vectored dispatch through mtvec. Sits between csr_reg, ex, id and control_tr.

---
 rtl/clint_vec.sv | 208 ++++++++++++++++++++
 tb/tb_clint_vec.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_vec.sv
// -----------------------------------------------------------------------------
// clint_vec - core-local interrupt controller with NUM_IRQ external sources.
//
// Latches the external lines into a pending register (per-source level or
// rising-edge trigger). In IDLE it arbitrates ECALL/EBREAK, enabled pending
// sources (lowest index wins) and MRET. It then runs the mepc/mstatus/mcause
// CSR write sequence and redirects ex, optionally through vectored mtvec.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   irq_i, irq_en_i      raw interrupt lines and per-source enables (mie)
//   global_int_en_i      mstatus.MIE
//   inst_i, inst_addr_i  instruction currently in id and its address
//   jump_flag_i/addr_i   ex jump taken and its target
//   div_started_i        divider busy
//   csr_mtvec_i/mepc_i/mstatus_i  current CSR values
//   hold_flag_o          pipeline hold to control_tr
//   csr_we_o/waddr_o/wdata_o      CSR write port
//   int_assert_o/addr_o  one-cycle redirect to ex and its target
//   irq_ack_o            one-hot acknowledge of the taken source
//   pending_o            pending register (mip image)
// -----------------------------------------------------------------------------
module clint_vec #(
    parameter int                   NUM_IRQ    = 8,
    parameter logic [NUM_IRQ-1:0]   EDGE_MASK  = '0,
    parameter int                   CAUSE_BASE = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_IRQ-1:0]  irq_i,
    input  logic [NUM_IRQ-1:0]  irq_en_i,
    input  logic                global_int_en_i,
    input  logic [31:0]         inst_i,
    input  logic [31:0]         inst_addr_i,
    input  logic                jump_flag_i,
    input  logic [31:0]         jump_addr_i,
    input  logic                div_started_i,
    input  logic [31:0]         csr_mtvec_i,
    input  logic [31:0]         csr_mepc_i,
    input  logic [31:0]         csr_mstatus_i,
    output logic                hold_flag_o,
    output logic                csr_we_o,
    output logic [31:0]         csr_waddr_o,
    output logic [31:0]         csr_wdata_o,
    output logic                int_assert_o,
    output logic [31:0]         int_addr_o,
    output logic [NUM_IRQ-1:0]  irq_ack_o,
    output logic [NUM_IRQ-1:0]  pending_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

    typedef enum logic [2:0] {
        S_IDLE, S_W_MEPC, S_W_MSTATUS, S_W_MCAUSE, S_W_MRET, S_JUMP
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_IRQ-1:0]  pending_q, irq_prev_q, irq_set, irq_masked, irq_ack;
    logic [4:0]          src_idx;
    logic                sync_exc, async_req, is_idle;
    logic                take_sync, take_async, take_mret, take_any;
    logic [31:0]         mepc_q, cause_q, mepc_d, cause_d;
    logic                mret_q;
    logic [31:0]         mtvec_base;

    // ---------------- pending register ----------------
    // Edge sources fire on 0->1 against last cycle's line; level sources fire
    // whenever the line is high. A new set beats the ack clear.
    assign irq_set    = (EDGE_MASK & irq_i & ~irq_prev_q) | (~EDGE_MASK & irq_i);
    assign irq_masked = pending_q & irq_en_i;
    assign async_req  = global_int_en_i & (|irq_masked);

    // Lowest enabled pending source wins: scan downwards so the lowest
    // index is the last one written.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a value
        // up front, otherwise a path that skips the assignment infers a latch.
        src_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_masked[i]) src_idx = 5'(i);
        end
    end

    // ---------------- arbitration (IDLE only) ----------------
    // A sync exception deferred by the divider blocks everything below it,
    // so the controller simply waits in IDLE and re-samples inst_i.
    assign is_idle    = (state_q == S_IDLE) & rst_ni;
    assign sync_exc   = (inst_i == INST_ECALL) | (inst_i == INST_EBREAK);
    assign take_sync  = is_idle & sync_exc & ~div_started_i;
    assign take_async = is_idle & ~sync_exc & async_req;
    assign take_mret  = is_idle & ~sync_exc & ~async_req & (inst_i == INST_MRET);
    assign take_any   = take_sync | take_async | take_mret;

    assign irq_ack = take_async ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << src_idx) : '0;

    always_comb begin
        mepc_d  = inst_addr_i;
        cause_d = 32'd0;
        if (take_sync) begin
            mepc_d  = jump_flag_i ? (jump_addr_i - 32'd4) : inst_addr_i;
            cause_d = (inst_i == INST_EBREAK) ? 32'd3 : 32'd11;
        end else if (take_async) begin
            if (jump_flag_i)        mepc_d = jump_addr_i;
            else if (div_started_i) mepc_d = inst_addr_i - 32'd4;
            cause_d = 32'h8000_0000 | (32'(CAUSE_BASE) + 32'(src_idx));
        end
    end

    // ---------------- sequential state ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            irq_prev_q <= '0;
            mepc_q     <= '0;
            cause_q    <= '0;
            mret_q     <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            state_q    <= state_d;
            pending_q  <= (pending_q & ~irq_ack) | irq_set;
            irq_prev_q <= irq_i;
            if (take_sync || take_async) begin
                mepc_q  <= mepc_d;
                cause_q <= cause_d;
                mret_q  <= 1'b0;
            end else if (take_mret) begin
                mret_q  <= 1'b1;
            end
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (take_sync || take_async) state_d = S_W_MEPC;
                else if (take_mret)          state_d = S_W_MRET;
            end
            S_W_MEPC:    state_d = S_W_MSTATUS;
            S_W_MSTATUS: state_d = S_W_MCAUSE;
            S_W_MCAUSE:  state_d = S_JUMP;
            S_W_MRET:    state_d = S_JUMP;
            S_JUMP:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    assign mtvec_base = {csr_mtvec_i[31:2], 2'b00};

    always_comb begin
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        case (state_q)
            S_W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = mepc_q;
            end
            S_W_MSTATUS: begin
                // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = {csr_mstatus_i[31:13], 2'b11, csr_mstatus_i[10:8],
                               csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0,
                               csr_mstatus_i[2:0]};
            end
            S_W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = cause_q;
            end
            S_W_MRET: begin
                // Trap return: MIE <= MPIE, MPIE <= 1.
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                               csr_mstatus_i[7], csr_mstatus_i[2:0]};
            end
            S_JUMP: begin
                int_assert_o = 1'b1;
                if (mret_q)
                    int_addr_o = csr_mepc_i;
                else if (csr_mtvec_i[1:0] == 2'b01 && cause_q[31])
                    int_addr_o = mtvec_base + {cause_q[29:0], 2'b00};
                else
                    int_addr_o = mtvec_base;
            end
            default: ;
        endcase
    end

    assign hold_flag_o = (state_q != S_IDLE) | take_any;
    assign irq_ack_o   = irq_ack;
    assign pending_o   = pending_q;

endmodule

// File: tb/tb_clint_vec.sv
// -----------------------------------------------------------------------------
// tb_clint_vec - directed scenarios followed by randomized traffic, every
// cycle compared against a transaction-level model: a pending set, and a
// queue of the per-cycle CSR writes / redirect each accepted trap produces.
// -----------------------------------------------------------------------------
module tb_clint_vec;

    localparam int          N       = 8;
    localparam logic [N-1:0] EDGE   = 8'hF0;
    localparam int          CBASE   = 16;
    localparam logic [31:0] ECALL   = 32'h0000_0073;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam logic [31:0] MRET    = 32'h3020_0073;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [N-1:0] irq_i, irq_en_i, irq_ack_o, pending_o;
    logic         global_int_en_i, jump_flag_i, div_started_i;
    logic [31:0]  inst_i, inst_addr_i, jump_addr_i;
    logic [31:0]  csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic         hold_flag_o, csr_we_o, int_assert_o;
    logic [31:0]  csr_waddr_o, csr_wdata_o, int_addr_o;

    always #5 clk_i = ~clk_i;

    clint_vec #(.NUM_IRQ(N), .EDGE_MASK(EDGE), .CAUSE_BASE(CBASE)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .irq_i(irq_i), .irq_en_i(irq_en_i),
        .global_int_en_i(global_int_en_i), .inst_i(inst_i),
        .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i),
        .jump_addr_i(jump_addr_i), .div_started_i(div_started_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
        .csr_mstatus_i(csr_mstatus_i), .hold_flag_o(hold_flag_o),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
        .csr_wdata_o(csr_wdata_o), .int_assert_o(int_assert_o),
        .int_addr_o(int_addr_o), .irq_ack_o(irq_ack_o), .pending_o(pending_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {X_MEPC, X_MSTATUS, X_MCAUSE, X_MRET, X_JUMP} slot_e;
    typedef struct {
        slot_e       what;
        logic [31:0] mepc;
        logic [31:0] cause;
        bit          mret;
    } slot_t;

    slot_t        sched[$];
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_prev = '0;

    task automatic model_reset();
        sched.delete();
        m_pend = '0;
        m_prev = '0;
    endtask

    task automatic push_trap(input logic [31:0] mepc, input logic [31:0] cause);
        sched.push_back('{X_MEPC,    mepc, cause, 1'b0});
        sched.push_back('{X_MSTATUS, mepc, cause, 1'b0});
        sched.push_back('{X_MCAUSE,  mepc, cause, 1'b0});
        sched.push_back('{X_JUMP,    mepc, cause, 1'b0});
    endtask

    // Called at a negedge with inputs already driven; compares this cycle's
    // outputs with the model, advances the model, returns at the next negedge.
    task automatic step();
        slot_t        s;
        logic         e_hold, e_we, e_as;
        logic [31:0]  e_wa, e_wd, e_ad, m;
        logic [N-1:0] e_ack, en_pend;
        bit           found;
        #2;
        e_hold = 0; e_we = 0; e_as = 0; e_wa = 0; e_wd = 0; e_ad = 0; e_ack = '0;
        if (sched.size() > 0) begin
            s = sched.pop_front();
            e_hold = 1;
            case (s.what)
                X_MEPC:    begin e_we = 1; e_wa = 32'h341; e_wd = s.mepc; end
                X_MCAUSE:  begin e_we = 1; e_wa = 32'h342; e_wd = s.cause; end
                X_MSTATUS: begin
                    m = csr_mstatus_i; m[7] = m[3]; m[3] = 1'b0; m[12:11] = 2'b11;
                    e_we = 1; e_wa = 32'h300; e_wd = m;
                end
                X_MRET: begin
                    m = csr_mstatus_i; m[3] = m[7]; m[7] = 1'b1;
                    e_we = 1; e_wa = 32'h300; e_wd = m;
                end
                X_JUMP: begin
                    e_as = 1;
                    if (s.mret) e_ad = csr_mepc_i;
                    else if (csr_mtvec_i[1:0] == 2'b01 && s.cause[31])
                        e_ad = (csr_mtvec_i & ~32'd3) + 4 * (s.cause & 32'h7FFF_FFFF);
                    else e_ad = csr_mtvec_i & ~32'd3;
                end
                default: ;
            endcase
        end else begin
            en_pend = m_pend & irq_en_i;
            if (inst_i == ECALL || inst_i == EBREAK) begin
                if (!div_started_i) begin
                    e_hold = 1;
                    push_trap(jump_flag_i ? jump_addr_i - 4 : inst_addr_i,
                              inst_i == ECALL ? 32'd11 : 32'd3);
                end
            end else if (global_int_en_i && en_pend != 0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && en_pend[k]) begin
                        found = 1;
                        e_ack[k] = 1'b1;
                        e_hold = 1;
                        push_trap(jump_flag_i ? jump_addr_i :
                                  div_started_i ? inst_addr_i - 4 : inst_addr_i,
                                  32'h8000_0000 + CBASE + k);
                    end
                end
            end else if (inst_i == MRET) begin
                e_hold = 1;
                sched.push_back('{X_MRET, 32'd0, 32'd0, 1'b1});
                sched.push_back('{X_JUMP, 32'd0, 32'd0, 1'b1});
            end
        end
        check("hold",    hold_flag_o,  e_hold);
        check("we",      csr_we_o,     e_we);
        check("waddr",   csr_waddr_o,  e_wa);
        check("wdata",   csr_wdata_o,  e_wd);
        check("assert",  int_assert_o, e_as);
        check("addr",    int_addr_o,   e_ad);
        check("ack",     irq_ack_o,    e_ack);
        check("pending", pending_o,    m_pend);
        for (int k = 0; k < N; k++) begin
            m_pend[k] = (EDGE[k] ? (irq_i[k] & ~m_prev[k]) : irq_i[k])
                        | (m_pend[k] & ~e_ack[k]);
        end
        m_prev = irq_i;
        @(negedge clk_i);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hold"},   hold_flag_o,  0);
        check({tag, "_we"},     csr_we_o,     0);
        check({tag, "_waddr"},  csr_waddr_o,  0);
        check({tag, "_wdata"},  csr_wdata_o,  0);
        check({tag, "_assert"}, int_assert_o, 0);
        check({tag, "_addr"},   int_addr_o,   0);
        check({tag, "_ack"},    irq_ack_o,    0);
        check({tag, "_pend"},   pending_o,    0);
    endtask

    // Edge pulse on source 5 through the full trap sequence.
    task automatic run_irq5(input logic [31:0] mtvec, input logic [31:0] exp_addr);
        csr_mtvec_i = mtvec;
        irq_i = 8'h20; step();
        irq_i = 8'h00;
        #1 check("i5_ack", irq_ack_o, 8'h20); check("i5_hold", hold_flag_o, 1); step();
        #1 check("i5_mepc_a", csr_waddr_o, 32'h341); check("i5_mepc", csr_wdata_o, 32'h100); step();
        #1 check("i5_mst_a", csr_waddr_o, 32'h300); check("i5_mst", csr_wdata_o, 32'h1880); step();
        #1 check("i5_mcause", csr_wdata_o, 32'h8000_0015); step();
        #1 check("i5_jump", int_assert_o, 1); check("i5_addr", int_addr_o, exp_addr); step();
    endtask

    initial begin
        rst_ni = 1'b0;
        irq_i = '0; irq_en_i = '0; global_int_en_i = 0; inst_i = NOP;
        inst_addr_i = 0; jump_flag_i = 0; jump_addr_i = 0; div_started_i = 0;
        csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0;
        repeat (2) @(negedge clk_i);
        #1 check_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();

        // Basic edge trap, direct then vectored mtvec.
        irq_en_i = 8'hFF; global_int_en_i = 1; inst_addr_i = 32'h100;
        csr_mstatus_i = 32'h8;
        run_irq5(32'h0000_0800, 32'h800);
        run_irq5(32'h0000_0801, 32'h854);
        csr_mtvec_i = 32'h800;

        // Simultaneous level source 2 and edge source 6.
        irq_i = 8'h44; step();
        irq_i = 8'h00;
        #1 check("two_ack2", irq_ack_o, 8'h04); step();
        #1 check("two_pend6", pending_o, 8'h40); step();
        step(); step(); step();
        #1 check("two_ack6", irq_ack_o, 8'h40); step();
        step(); step();
        #1 check("two_mcause", csr_wdata_o, 32'h8000_0016); step();
        step();

        // ECALL deferred by the divider.
        inst_i = ECALL; div_started_i = 1; inst_addr_i = 32'h300;
        repeat (3) begin
            #1 check("ecall_defer_we", csr_we_o, 0); check("ecall_defer_hold", hold_flag_o, 0); step();
        end
        div_started_i = 0;
        #1 check("ecall_hold0", hold_flag_o, 1); step();
        inst_i = NOP;
        #1 check("ecall_mepc", csr_wdata_o, 32'h300); check("ecall_hold1", hold_flag_o, 1); step();
        #1 check("ecall_hold2", hold_flag_o, 1); step();
        #1 check("ecall_mcause", csr_wdata_o, 32'd11); check("ecall_hold3", hold_flag_o, 1); step();
        #1 check("ecall_jump", int_assert_o, 1); check("ecall_hold4", hold_flag_o, 1); step();

        // MRET.
        inst_i = MRET; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h200;
        #1 check("mret_hold", hold_flag_o, 1); step();
        inst_i = NOP;
        #1 check("mret_waddr", csr_waddr_o, 32'h300); check("mret_wdata", csr_wdata_o, 32'h88); step();
        #1 check("mret_jump", int_assert_o, 1); check("mret_addr", int_addr_o, 32'h200); step();

        // Reset in the middle of a trap sequence (state now W_MSTATUS).
        irq_i = 8'h20; step();
        irq_i = 8'h00; step();
        step();
        rst_ni = 1'b0;
        #1 check_all_zero("midrst");
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (6) step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int r;
            irq_i           = N'($urandom & $urandom & $urandom);
            irq_en_i        = N'($urandom | $urandom);
            global_int_en_i = ($urandom_range(0, 7) != 0);
            r = $urandom_range(0, 9);
            inst_i          = (r == 0) ? ECALL : (r == 1) ? EBREAK : (r == 2) ? MRET : NOP;
            inst_addr_i     = $urandom & ~32'd3;
            jump_flag_i     = ($urandom_range(0, 2) == 0);
            jump_addr_i     = $urandom & ~32'd3;
            div_started_i   = ($urandom_range(0, 3) == 0);
            csr_mtvec_i     = $urandom;
            csr_mepc_i      = $urandom;
            csr_mstatus_i   = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
